sr_display_driver: RTL

SR_DISPLAY_DRIVER -- requirements
Module: sr_display_driver

---
 rtl/sr_display_driver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sr_display_driver.sv
// Serialises a hex value (with optional minus sign or "Err") as a chain of
// 7-segment bytes into external shift registers, then pulses the storage latch.
module sr_display_driver #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_DIGITS     = 5,
    parameter int SR_CLK_DIV     = 2,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_is_neg,
    input  logic                  i_error,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch
);

    localparam int FRAME_W = NUM_DIGITS * 8;
    localparam int EXT_W   = (DATA_WIDTH > 4 * NUM_DIGITS) ? DATA_WIDTH : 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(SR_CLK_DIV + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_R     = 8'h50;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIT_W-1:0]   bit_q;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_d;
    logic               sr_data_q;
    logic               sr_clk_q;
    logic               latch_q;
    logic               ready_q;

    logic [EXT_W-1:0]   data_ext;
    logic               minus_placed;
    logic               err_frame;
    logic [7:0]         seg;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'h3F;
            4'h1: hex_seg = 8'h06;
            4'h2: hex_seg = 8'h5B;
            4'h3: hex_seg = 8'h4F;
            4'h4: hex_seg = 8'h66;
            4'h5: hex_seg = 8'h6D;
            4'h6: hex_seg = 8'h7D;
            4'h7: hex_seg = 8'h07;
            4'h8: hex_seg = 8'h7F;
            4'h9: hex_seg = 8'h6F;
            4'hA: hex_seg = 8'h77;
            4'hB: hex_seg = 8'h7C;
            4'hC: hex_seg = 8'h39;
            4'hD: hex_seg = 8'h5E;
            4'hE: hex_seg = 8'h79;
            default: hex_seg = 8'h71;
        endcase
    endfunction

    // Digit 0 is frame_d[7:0]; the minus lands on the first blanked digit above the MSD.
    always_comb begin
        data_ext     = EXT_W'(i_data);
        frame_d      = '0;
        minus_placed = 1'b0;
        seg          = SEG_BLANK;
        err_frame    = i_error || ((data_ext >> (4 * NUM_DIGITS)) != '0);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i == 0 || (data_ext >> (4 * i)) != '0) begin
                seg = hex_seg(data_ext[4*i +: 4]);
            end else if (i_data_is_neg && data_ext != '0 && !minus_placed) begin
                seg          = SEG_MINUS;
                minus_placed = 1'b1;
            end else begin
                seg = SEG_BLANK;
            end
            frame_d[8*i +: 8] = seg;
        end
        if (i_data_is_neg && data_ext != '0 && !minus_placed) begin
            err_frame = 1'b1;
        end
        if (err_frame) begin
            frame_d        = '0;
            frame_d[23:0]  = {SEG_E, SEG_R, SEG_R};
        end
        if (SEG_ACTIVE_LOW != 0) begin
            frame_d = ~frame_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            sr_data_q <= 1'b0;
            sr_clk_q  <= 1'b0;
            latch_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && ready_q) begin
                        sr_data_q <= frame_d[FRAME_W-1];
                        frame_q   <= {frame_d[FRAME_W-2:0], 1'b0};
                        sr_clk_q  <= 1'b0;
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (cnt_q == CNT_W'(SR_CLK_DIV - 1)) begin
                        cnt_q    <= '0;
                        sr_clk_q <= 1'b1;
                        state_q  <= SHIFT_HI;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (cnt_q == CNT_W'(SR_CLK_DIV - 1)) begin
                        cnt_q    <= '0;
                        sr_clk_q <= 1'b0;
                        if (bit_q == BIT_W'(FRAME_W - 1)) begin
                            sr_data_q <= 1'b0;
                            latch_q   <= 1'b1;
                            state_q   <= LATCH;
                        end else begin
                            bit_q     <= bit_q + BIT_W'(1);
                            sr_data_q <= frame_q[FRAME_W-1];
                            frame_q   <= {frame_q[FRAME_W-2:0], 1'b0};
                            state_q   <= SHIFT_LO;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LATCH: begin
                    if (cnt_q == CNT_W'(SR_CLK_DIV - 1)) begin
                        cnt_q   <= '0;
                        latch_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready    = ready_q & ~rst;
    assign o_sr_data  = sr_data_q;
    assign o_sr_clk   = sr_clk_q;
    assign o_sr_latch = latch_q;

endmodule
